if_fetch_ctrl: RTL
==================

Name: if_fetch_ctrl

Overview:
Sequencer for the 16-bit processor's instruction-fetch stage.
- Owns the program counter and the PC-select decision (sequential or branch redirect).
- Drives the instruction-memory request/acknowledge handshake and presents fetched instructions to decode through a one-entry valid/ready output register.
- Sits between the hazard unit (pc_write), the branch logic (branch_taken/branch_target), instruction memory and the IF/ID boundary.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
PC_INC, 16'd1, sequential PC increment (word-addressed memory).
TIMEOUT, 15, max cycles imem_req may stay high without imem_ack before error.

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
pc_write  in  1  hazard unit: 1 = new fetches may be issued, 0 = stall issuance.
branch_taken  in  1  one-cycle redirect pulse.
branch_target  in  16  redirect PC, valid with branch_taken.
imem_req  out  1  fetch request; held high until imem_ack.
imem_addr  out  16  fetch address; stable while imem_req=1.
imem_ack  in  1  memory acknowledge, sampled on clock edge while imem_req=1.
imem_rdata  in  16  instruction word, valid with imem_ack.
instr_valid  out  1  output register holds an instruction.
instr_out  out  16  fetched instruction.
instr_pc  out  16  PC of instr_out.
id_ready  in  1  decode accepts; transfer on instr_valid&&id_ready at the edge.
pc_out  out  16  current PC register.
fetch_err  out  1  sticky timeout error.

Behaviour:
- Reset (async, reset_n=0):
  - pc=RESET_PC; state=IDLE.
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_out=0, instr_pc=0, fetch_err=0, timeout counter=0.
- States: IDLE, FETCH, HOLD, DRAIN, ERROR.
  - imem_req=1 only in FETCH and DRAIN.
  - imem_addr=pc in FETCH; the latched in-flight address in DRAIN.
- valid_next = output-register valid after this edge: set by a captured ack, cleared by a transfer or a redirect.
- IDLE / HOLD -> FETCH when pc_write=1 && valid_next=0; otherwise stay. IDLE always exits after the first post-reset cycle.
- FETCH, edge with imem_ack=1:
  - instr_out<=imem_rdata; instr_pc<=pc; instr_valid<=1; pc<=pc+PC_INC.
  - Next state = HOLD.
  - Minimum issue interval: request, ack, hold, so at most one instruction per 3 cycles with 1-cycle memory.
- FETCH, edge with imem_ack=0: stay; increment the timeout counter.
- pc_write=0 gates only issuance of new requests. An outstanding request still completes, captures its data and increments pc.
- Redirect (branch_taken=1) has priority over everything except reset:
  - pc<=branch_target; instr_valid<=0 (flush, even if id_ready=1).
  - In FETCH without ack: go to DRAIN. imem_req stays high on the old address, and the eventual ack data is discarded.
  - In FETCH with ack on the same edge: discard the data, pc<=branch_target, next = HOLD rules.
  - In DRAIN, ack -> HOLD. A second redirect while in DRAIN just overwrites pc.
- Output register:
  - Holds until transferred: instr_valid&&id_ready at an edge with no new capture -> instr_valid<=0.
  - instr_out and instr_pc are held while stalled.
- Timeout:
  - The counter clears on every ack and on entry to FETCH or DRAIN.
  - When it reaches TIMEOUT with no ack: fetch_err<=1, imem_req drops, state=ERROR.
  - ERROR is left only by reset; all inputs are ignored there.
- Arithmetic: pc+PC_INC is modulo 2^16 (16'hFFFF+1 -> 16'h0000). branch_target is used verbatim.
- Reset mid-request: imem_req drops asynchronously. Any later stale ack is ignored because the controller is in IDLE.

Decomposition:
- Shared package if_pkg:
  - State encoding constants (IDLE, FETCH, HOLD, DRAIN, ERROR).
  - RESET_PC default, 16-bit instruction and address width constants.
- One sub-module: if_timeout_ctr. Width $clog2(TIMEOUT+1), inputs clr/en, output expired.
- The PC register, next-PC mux and output register stay inline.

Test Plan:
- Reset then sequential fetch, 1-cycle ack, id_ready=1, imem_rdata=16'hA000+addr.
  -> imem_addr 0,1,2 in successive FETCH states.
  -> instr_out 16'hA000, 16'hA001, 16'hA002 with instr_pc 0, 1, 2; no duplicates or skips.
- id_ready=0 for 5 cycles after the first capture.
  -> instr_valid stays 1 and instr_out stays 16'hA000.
  -> No imem_req asserted; fetch of address 1 starts the cycle after the transfer.
- pc_write=0 while a request to address 4 is outstanding with 3-cycle latency.
  -> Instruction 4 is captured and pc becomes 5; no request for address 5 until pc_write=1.
- branch_taken with branch_target=16'h0100 while FETCH on address 7 is awaiting ack.
  -> imem_req held on address 7 until ack, data discarded, instr_valid=0.
  -> Next request address = 16'h0100.
- RESET_PC=16'hFFFF, first ack.
  -> instr_pc=16'hFFFF and the next imem_addr=16'h0000.
- No ack for 15 cycles.
  -> fetch_err=1 and imem_req=0, stays in ERROR.
  -> reset_n low mid-cycle clears everything asynchronously; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
`default_nettype none

package if_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0] IF_RESET_PC = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ERROR = 3'd4
  } if_state_e;

endpackage

`default_nettype wire

// File: rtl/if_timeout_ctr.sv
// Counts request cycles without acknowledge; flags the edge on which TIMEOUT is reached.
`default_nettype none

module if_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  // High on the edge whose increment would bring the count to TIMEOUT.
  assign expired = en && (count == LAST);

endmodule

`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: PC ownership, imem handshake and one-entry IF/ID output register.
`default_nettype none

module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = IF_RESET_PC,
  parameter logic [ADDR_W-1:0] PC_INC   = 16'd1,
  parameter int                TIMEOUT  = 15
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               pc_write,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               id_ready,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               fetch_err
);

  if_state_e           state, state_nx;
  logic [ADDR_W-1:0]   pc, pc_nx, req_addr;
  logic                req_active, ack_seen, capture, valid_nx;
  logic                tmo_clr, tmo_en, tmo_expired;

  assign req_active = (state == ST_FETCH) || (state == ST_DRAIN);
  assign ack_seen   = req_active && imem_ack;
  assign capture    = (state == ST_FETCH) && imem_ack && !branch_taken;

  always_comb begin
    valid_nx = instr_valid;
    if (state != ST_ERROR) begin
      if (branch_taken) begin
        valid_nx = 1'b0;
      end else if (capture) begin
        valid_nx = 1'b1;
      end else if (instr_valid && id_ready) begin
        valid_nx = 1'b0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    unique case (state)
      ST_IDLE, ST_HOLD: begin
        if (pc_write && !valid_nx) begin
          state_nx = ST_FETCH;
        end else begin
          state_nx = ST_HOLD;
        end
      end
      ST_FETCH: begin
        if (imem_ack) begin
          state_nx = ST_HOLD;
        end else if (branch_taken) begin
          state_nx = ST_DRAIN;
        end else if (tmo_expired) begin
          state_nx = ST_ERROR;
        end
      end
      ST_DRAIN: begin
        if (imem_ack) begin
          state_nx = ST_HOLD;
        end else if (tmo_expired) begin
          state_nx = ST_ERROR;
        end
      end
      ST_ERROR: state_nx = ST_ERROR;
      default:  state_nx = ST_ERROR;
    endcase

    if (state != ST_ERROR) begin
      if (branch_taken) begin
        pc_nx = branch_target;
      end else if (capture) begin
        pc_nx = pc + PC_INC;
      end
    end
  end

  // Counter restarts on every ack and whenever a new request phase begins.
  assign tmo_en  = req_active && !imem_ack;
  assign tmo_clr = ack_seen ||
                   (((state_nx == ST_FETCH) || (state_nx == ST_DRAIN)) && (state_nx != state));

  if_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= '0;
      fetch_err   <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      instr_valid <= valid_nx;
      // Keeps the address of the in-flight request once a redirect moves pc away.
      if (state == ST_FETCH) begin
        req_addr <= pc;
      end
      if (capture) begin
        instr_out <= imem_rdata;
        instr_pc  <= pc;
      end
      if (state_nx == ST_ERROR) begin
        fetch_err <= 1'b1;
      end
    end
  end

  assign imem_req  = req_active;
  assign imem_addr = (state == ST_DRAIN) ? req_addr : pc;
  assign pc_out    = pc;

endmodule

`default_nettype wire
